// File: rtl/rng_scalar_sampler_if.sv
// Request/response bundle between the scalar sampler and the signing datapath.
interface rng_scalar_sampler_if;
    logic         req_valid;
    logic         req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] scalar;
    logic [7:0]   rej_count;
    logic         fail;

    modport master (
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  scalar,
        input  rej_count,
        input  fail
    );

    modport slave (
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_valid,
        output scalar,
        output rej_count,
        output fail
    );
endinterface

// File: rtl/rng_scalar_sampler.sv
// Draws a uniform nonzero scalar below the Ed25519 group order from a free-running
// 256-bit LFSR. Each capture waits for a fully refreshed word. Zero words, repeated
// words and runs of too many rejections latch a sticky failure.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request
// S_WAIT  | counting down until the LFSR word is fully refreshed
// S_CHECK | health checks on the captured word, then range check vs L
// S_DONE  | scalar presented, waiting for the consumer
// S_FAIL  | sticky health failure, left only through reset
module rng_scalar_sampler #(
    parameter int unsigned REFRESH_CYCLES = 256,
    parameter int unsigned MAX_REJECTS    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [255:0]          rnd_in,
    rng_scalar_sampler_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [255:0] L_ORDER =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
    localparam logic [15:0]  CNT_RELOAD = 16'(REFRESH_CYCLES - 1);
    localparam logic [7:0]   REJ_LIMIT  = 8'(MAX_REJECTS);

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [255:0] cand_q, cand_d;
    logic [255:0] raw_q, raw_d;
    logic [255:0] prev_q, prev_d;
    logic [255:0] scalar_q, scalar_d;
    logic [7:0]   rej_q, rej_d;

    logic [7:0]   rej_inc;
    logic         cand_reject;

    // Full-width unsigned compare keeps the accepted distribution unbiased.
    assign rej_inc     = rej_q + 8'd1;
    assign cand_reject = (cand_q == '0) || (cand_q >= L_ORDER);

    // Next-state and datapath updates; every register holds unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        raw_d    = raw_q;
        prev_d   = prev_q;
        scalar_d = scalar_q;
        rej_d    = rej_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cnt_d   = CNT_RELOAD;
                    rej_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cand_d  = {3'b000, rnd_in[252:0]};
                    raw_d   = rnd_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (raw_q == '0) begin
                    state_d = S_FAIL;
                end else if (raw_q == prev_q) begin
                    state_d = S_FAIL;
                end else begin
                    // Only healthy captures become the reference for the repeat check.
                    prev_d = raw_q;
                    if (cand_reject) begin
                        rej_d = rej_inc;
                        if (rej_inc == REJ_LIMIT) begin
                            state_d = S_FAIL;
                        end else begin
                            cnt_d   = CNT_RELOAD;
                            state_d = S_WAIT;
                        end
                    end else begin
                        scalar_d = cand_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            raw_q    <= '0;
            prev_q   <= '0;
            scalar_q <= '0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            scalar_q <= scalar_d;
            rej_q    <= rej_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.fail      = (state_q == S_FAIL);
    assign bus.scalar    = scalar_q;
    assign bus.rej_count = rej_q;

endmodule

// File: doc/rng_scalar_sampler.md
# rng_scalar_sampler

Consumer side of the 256-bit LFSR random source. On request it waits for the LFSR to shift in a fully fresh 256-bit word, samples it, and masks it to 253 bits. It rejection-samples the result against the Ed25519 group order L and returns a uniform nonzero scalar below L to the signing datapath. It also runs continuous health checks (zero word, repeated word, excessive rejections) and latches a sticky failure.

## Interface
- REFRESH_CYCLES, 256: clocks between successive captures of rnd_in (LFSR shifts one bit per clk); legal range 1..65535.
- MAX_REJECTS, 64: rejections allowed per request before failure; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rnd_in  in  256  live LFSR state, sampled only in the capture cycle.
- req_valid  in  1  request for one scalar.
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready.
- out_valid  out  1  scalar valid; high only in DONE.
- out_ready  in  1  consumer accepts the scalar on the edge where out_valid && out_ready.
- scalar  out  256  sampled scalar, with bits [255:253] always 0 and the value < L.
- rej_count  out  8  rejections in the current request; cleared on request accept.
- fail  out  1  sticky health failure; cleared only by rst.

## Operation
- L = 0x1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed.
- **IDLE**
  - req_ready=1.
  - On accept: cnt <= REFRESH_CYCLES-1, rej_count <= 0, go WAIT.
- **WAIT**
  - If cnt != 0, cnt decrements.
  - If cnt == 0: cand <= {3'b0, rnd_in[252:0]}, raw <= rnd_in, go CHECK.
- **CHECK**, evaluated in this priority order:
  1. raw == 0 -> FAIL.
  2. raw == prev (prev = last captured raw word, any request) -> FAIL.
  3. Otherwise prev <= raw.
     - If cand == 0 or cand >= L: this is a rejection, and rej_count increments.
       - If the incremented value equals MAX_REJECTS -> FAIL.
       - Otherwise cnt <= REFRESH_CYCLES-1 and go WAIT.
     - If 0 < cand < L: scalar <= cand, go DONE.
- **DONE**
  - out_valid=1, and scalar is held stable.
  - On out_ready -> IDLE.
- **FAIL**
  - fail=1, req_ready=0, out_valid=0.
  - Terminal until rst.
  - scalar keeps its last value; rej_count freezes.
- Comparison is a full 256-bit unsigned compare. No reduction is applied, so the accepted distribution is unbiased.
- prev is updated only on non-failing captures. prev resets to 0, so the first capture cannot false-trigger the repeat check; an all-zero word is caught by rule 1.

## Timing
- **Reset:**
  - Outputs: req_ready=1, out_valid=0, scalar=0, rej_count=0, fail=0.
  - Internal: state=IDLE, cnt=0, prev=0, cand=0, raw=0.
  - Reset is asynchronous and can occur in any state, including mid-WAIT or DONE. The block returns to IDLE and any in-flight scalar is discarded.
- **Latency with no rejections.** Define the accept edge as edge 0.
  - Capture occurs at edge REFRESH_CYCLES.
  - CHECK takes 1 cycle, so out_valid rises after edge REFRESH_CYCLES+1 (257 clocks at the default).
  - Each rejection adds REFRESH_CYCLES+1 clocks.
- **Handshakes:**
  - req_ready is registered from the state.
  - A req_valid held high while the block is not in IDLE is ignored; it is accepted on the first IDLE cycle.
  - out_valid stays high until out_ready. Backpressure of any length is allowed, and scalar does not change during it.
  - After the out handshake, req_ready=1 on the next cycle. A back-to-back request is therefore accepted at the earliest 1 cycle after the out handshake.
- **FAIL entry:** fail rises on the edge leaving CHECK; out_valid never pulses for a failing capture.
- **cnt wrap:** cnt never underflows; it reloads only on accept or rejection.
- **REFRESH_CYCLES=1:** capture occurs on the first WAIT cycle.

## Test plan
- **Reset values.** Hold rst=0 for 3 cycles then release. Required: req_ready=1, out_valid=0, fail=0, scalar=0, rej_count=0. Then drive the real LFSR (seed A5..A5) and pulse one req. Required: out_valid after exactly 257 clocks, scalar < L, bits [255:253]=0, scalar equal to the masked LFSR state at the capture edge.
- **Boundary values.** Force rnd_in=L and issue a req: expect rej_count=1 and back to WAIT. Then switch rnd_in to L-1 before the next capture: expect scalar=L-1 and rej_count=1. A word with only bit 255 set (masked cand=0) is rejected, not failed.
- **Rejection limit.** With MAX_REJECTS=4, drive rnd_in values all ≥ L and all distinct. Required: fail=1 at the 4th CHECK, rej_count=4, out_valid never asserted, req_ready=0 thereafter.
- **Health checks.**
  - Constant rnd_in=0x1234 for two requests: the first returns scalar=0x1234, the second sets fail (repeated word).
  - After rst, rnd_in=0 sets fail at the first CHECK.
- **Backpressure.** Hold out_ready=0 for 20 cycles after out_valid while rnd_in keeps changing. Required: scalar and out_valid stable throughout. When out_ready goes high, the next cycle is IDLE, and a held req_valid is accepted one cycle later.
- **Reset mid-operation.** Assert rst for 1 cycle during WAIT (cnt=100). Required: immediate return to IDLE with out_valid=0 and fail=0. A new request then completes with the full 257-clock latency.
